post_cov_semipar: RTL and testbench



---
 rtl/post_cov_semipar_pkg.sv | 8 +
 rtl/post_cov_semipar_if.sv | 21 ++
 rtl/fxp_add.sv | 10 +
 rtl/fxp_mul.sv | 11 +
 rtl/post_cov_semipar.sv | 97 +++++++++
 tb/tb_post_cov_semipar.sv | 196 +++++++++++++++++++
 6 files changed

// File: rtl/post_cov_semipar_pkg.sv
// post_cov_semipar_pkg: fixed-point widths and FSM types shared by the
// posterior-covariance update slice.
package post_cov_semipar_pkg;
  localparam int FXP_N = 16;
  localparam int FXP_FRAC = 8;
  localparam logic [2:0] LAST_CYC = 3'd7;
  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/post_cov_semipar_if.sv
// post_cov_semipar_if: start/done handshake, operand matrices and posterior
// covariance result bundled for the covariance update block.
interface post_cov_semipar_if
  import post_cov_semipar_pkg::*;
#(
  parameter int N = FXP_N
);
  logic start, busy, done;
  logic signed [N-1:0] pp00, pp01, pp10, pp11;
  logic signed [N-1:0] k00, k01, k10, k11;
  logic signed [N-1:0] h00, h01, h10, h11;
  logic signed [N-1:0] P_POST00, P_POST01, P_POST10, P_POST11;
  modport master (
    output start, pp00, pp01, pp10, pp11, k00, k01, k10, k11, h00, h01, h10, h11,
    input  busy, done, P_POST00, P_POST01, P_POST10, P_POST11
  );
  modport slave (
    input  start, pp00, pp01, pp10, pp11, k00, k01, k10, k11, h00, h01, h10, h11,
    output busy, done, P_POST00, P_POST01, P_POST10, P_POST11
  );
endinterface

// File: rtl/fxp_add.sv
// fxp_add: signed W-bit adder that wraps on overflow.
module fxp_add #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);
  assign y = a + b;
endmodule

// File: rtl/fxp_mul.sv
// fxp_mul: signed N x N multiplier returning the full 2N-bit product.
module fxp_mul #(
  parameter int N = 16
) (
  input  logic signed [N-1:0]   a,
  input  logic signed [N-1:0]   b,
  output logic signed [2*N-1:0] y_full
);
  typedef logic signed [2*N-1:0] ww_t;
  assign y_full = ww_t'(a) * ww_t'(b);
endmodule

// File: rtl/post_cov_semipar.sv
// post_cov_semipar: P_post = P - K*(H*P) on four shared multipliers and two
// 2N adders over eight cycles, with captured operands and start/done.
module post_cov_semipar
  import post_cov_semipar_pkg::*;
#(
  parameter int N = FXP_N,
  parameter int FRAC = FXP_FRAC
) (
  input logic clk,
  input logic rst_n,
  post_cov_semipar_if.slave bus
);
  typedef logic signed [N-1:0] w_t;
  typedef logic signed [2*N-1:0] ww_t;
  function automatic w_t trunc(input ww_t x);
    return w_t'(x >>> FRAC);
  endfunction
  function automatic ww_t align(input w_t x);
    return ww_t'(x) <<< FRAC;
  endfunction
  state_e state_q, state_d;
  logic [2:0] cyc_q, cyc_d;
  logic done_q, done_d;
  logic accept, col;
  w_t pp_q [4], k_q [4], h_q [4], m_q [4];
  w_t opa_q [4], opb_q [4], opa_d [4], opb_d [4];
  ww_t s_q [4], prod [4];
  ww_t sum_a, sum_b;
  assign accept = bus.start && state_q == IDLE;
  assign col = cyc_q[1];
  always_comb begin
    state_d = state_q;
    cyc_d = cyc_q;
    done_d = 1'b0;
    if (accept) begin
      state_d = RUN;
      cyc_d = '0;
    end else if (state_q == RUN) begin
      cyc_d = cyc_q + 3'd1;
      state_d = cyc_q == LAST_CYC ? IDLE : RUN;
      done_d = cyc_q == LAST_CYC;
    end
  end
  // Even cycles: H*P (cyc<4) or K*M (cyc>=4) on column col; lanes 0/1 form row 0, lanes 2/3 row 1.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      opa_d[i] = cyc_q[2] ? k_q[i] : h_q[i];
      opb_d[i] = cyc_q[2] ? m_q[{i[0], col}] : pp_q[{i[0], col}];
    end
  end
  for (genvar g = 0; g < 4; g++) begin : g_mul
    fxp_mul #(.N(N)) u_mul (.a(opa_q[g]), .b(opb_q[g]), .y_full(prod[g]));
  end
  fxp_add #(.W(2*N)) u_add_a (.a(prod[0]), .b(prod[1]), .y(sum_a));
  fxp_add #(.W(2*N)) u_add_b (.a(prod[2]), .b(prod[3]), .y(sum_b));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q <= '0;
      done_q <= 1'b0;
      pp_q <= '{default: '0};
      k_q <= '{default: '0};
      h_q <= '{default: '0};
      m_q <= '{default: '0};
      opa_q <= '{default: '0};
      opb_q <= '{default: '0};
      s_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cyc_q <= cyc_d;
      done_q <= done_d;
      if (accept) begin
        pp_q <= '{bus.pp00, bus.pp01, bus.pp10, bus.pp11};
        k_q <= '{bus.k00, bus.k01, bus.k10, bus.k11};
        h_q <= '{bus.h00, bus.h01, bus.h10, bus.h11};
      end
      if (state_q == RUN && !cyc_q[0]) begin
        opa_q <= opa_d;
        opb_q <= opb_d;
      end
      if (state_q == RUN && cyc_q[0] && !cyc_q[2]) begin
        m_q[{1'b0, col}] <= trunc(sum_a);
        m_q[{1'b1, col}] <= trunc(sum_b);
      end
      if (state_q == RUN && cyc_q[0] && cyc_q[2]) begin
        s_q[{1'b0, col}] <= align(pp_q[{1'b0, col}]) - sum_a;
        s_q[{1'b1, col}] <= align(pp_q[{1'b1, col}]) - sum_b;
      end
    end
  end
  assign bus.busy = state_q == RUN;
  assign bus.done = done_q;
  assign bus.P_POST00 = trunc(s_q[0]);
  assign bus.P_POST01 = trunc(s_q[1]);
  assign bus.P_POST10 = trunc(s_q[2]);
  assign bus.P_POST11 = trunc(s_q[3]);
endmodule

// File: tb/tb_post_cov_semipar.sv
// tb_post_cov_semipar: scoreboard bench for the posterior covariance update
// (N=16, FRAC=8); matrices packed as {x00,x01,x10,x11}.
module tb_post_cov_semipar;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];
  always #5 clk = ~clk;
  post_cov_semipar_if bus ();
  post_cov_semipar dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {16'(a), 16'(b), 16'(c), 16'(d)};
  endfunction
  function automatic logic [63:0] model(input logic [63:0] ppv, input logic [63:0] kv, input logic [63:0] hv);
    logic signed [15:0] p [4], k [4], h [4], m [4];
    logic signed [31:0] acc;
    logic [63:0] res;
    for (int i = 0; i < 4; i++) begin
      p[i] = ppv[63-16*i -: 16];
      k[i] = kv[63-16*i -: 16];
      h[i] = hv[63-16*i -: 16];
    end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        acc = 32'(h[2*r]) * 32'(p[c]) + 32'(h[2*r+1]) * 32'(p[2+c]);
        m[2*r+c] = acc[23:8];
      end
    res = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        acc = (32'(p[2*r+c]) <<< 8) - (32'(k[2*r]) * 32'(m[c]) + 32'(k[2*r+1]) * 32'(m[2+c]));
        res[63-16*(2*r+c) -: 16] = acc[23:8];
      end
    return res;
  endfunction
  function automatic logic [63:0] get_out();
    return {bus.P_POST00, bus.P_POST01, bus.P_POST10, bus.P_POST11};
  endfunction
  task automatic set_ops(input logic [63:0] ppv, input logic [63:0] kv, input logic [63:0] hv);
    {bus.pp00, bus.pp01, bus.pp10, bus.pp11} = ppv;
    {bus.k00, bus.k01, bus.k10, bus.k11} = kv;
    {bus.h00, bus.h01, bus.h10, bus.h11} = hv;
  endtask
  localparam logic [63:0] EYE = 64'h0100_0000_0000_0100;
  localparam logic [63:0] C2_PP = 64'h0100_0080_0080_0200;
  localparam logic [63:0] C2_K = 64'h0080_0000_0000_0040;
  localparam logic [63:0] C2_P = 64'h0080_0040_0060_0180;
  task automatic run_op(input logic [63:0] ppv, input logic [63:0] kv, input logic [63:0] hv,
                        input logic [63:0] want, input string name);
    int cnt;
    int busy_n;
    logic [63:0] exp;
    @(negedge clk);
    set_ops(ppv, kv, hv);
    bus.start = 1'b1;
    exp_q.push_back(model(ppv, kv, hv));
    @(negedge clk);
    bus.start = 1'b0;
    set_ops(~ppv, ~kv, ~hv);
    cnt = 1;
    busy_n = 0;
    while (!bus.done && cnt < 40) begin
      busy_n += int'(bus.busy);
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt !== 9) begin errors++; $display("FAIL %s latency got %0d want 9", name, cnt); end
    checks++;
    if (busy_n !== 8) begin errors++; $display("FAIL %s busy_cycles got %0d want 8", name, busy_n); end
    checks++;
    if (!bus.done) begin
      errors++;
      $display("FAIL %s done_timeout got done=0 want done=1", name);
      void'(exp_q.pop_front());
    end else begin
      exp = exp_q.pop_front();
      if (get_out() !== exp) begin errors++; $display("FAIL %s model got %h want %h", name, get_out(), exp); end
      checks++;
      if (get_out() !== want) begin errors++; $display("FAIL %s result got %h want %h", name, get_out(), want); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b want 0", name, bus.busy); end
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL %s done_width got %b want 0", name, bus.done); end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b1;
    set_ops(C2_PP, C2_K, EYE);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    checks++;
    if (get_out() !== 64'd0) begin errors++; $display("FAIL reset_out got %h want 0", get_out()); end
    bus.start = 1'b0;
    rst_n = 1'b1;
  endtask
  task automatic test_basic();
    run_op(pk(300, -20, -20, 700), 64'd0, EYE, pk(300, -20, -20, 700), "k_zero");
    run_op(C2_PP, C2_K, EYE, C2_P, "k_diag");
    run_op(pk(256, -128, -128, 512), EYE, EYE, 64'd0, "k_eye");
    run_op(pk(100, 50, -30, 200), pk(64, 32, -16, 128), pk(256, 128, 0, -256),
           model(pk(100, 50, -30, 200), pk(64, 32, -16, 128), pk(256, 128, 0, -256)), "mixed");
  endtask
  task automatic test_overflow();
    run_op(pk(32767, 0, 0, 0), pk(-256, 0, 0, -256), EYE, pk(-2, 0, 0, 0), "overflow");
  endtask
  task automatic test_back_to_back();
    int d1;
    int d2;
    logic [63:0] exp;
    @(negedge clk);
    set_ops(C2_PP, C2_K, EYE);
    bus.start = 1'b1;
    exp_q.push_back(model(C2_PP, C2_K, EYE));
    exp_q.push_back(model(C2_PP, C2_K, EYE));
    d1 = 0;
    d2 = 0;
    for (int cnt = 1; cnt <= 40 && d2 == 0; cnt++) begin
      @(negedge clk);
      if (cnt == 1 || cnt == 10) set_ops(~C2_PP, ~C2_K, ~EYE);
      if (cnt == 12) bus.start = 1'b0;
      if (cnt == 13) bus.start = 1'b1;
      if (bus.done) begin
        exp = exp_q.size() > 0 ? exp_q.pop_front() : 64'hx;
        checks++;
        if (get_out() !== exp) begin errors++; $display("FAIL b2b_result got %h want %h", get_out(), exp); end
        if (d1 == 0) begin
          d1 = cnt;
          set_ops(C2_PP, C2_K, EYE);
        end else begin
          d2 = cnt;
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    checks++;
    if (d1 !== 9) begin errors++; $display("FAIL b2b_first got %0d want 9", d1); end
    checks++;
    if (d2 !== 18) begin errors++; $display("FAIL b2b_second got %0d want 18", d2); end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_queue got %0d want 0", exp_q.size()); end
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", bus.busy); end
  endtask
  task automatic test_abort();
    int seen;
    @(negedge clk);
    set_ops(C2_PP, C2_K, EYE);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL abort_ctrl got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    checks++;
    if (get_out() !== 64'd0) begin errors++; $display("FAIL abort_out got %h want 0", get_out()); end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_beats_start got %b want 0", bus.busy); end
    rst_n = 1'b1;
    bus.start = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen += int'(bus.done);
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", seen); end
    run_op(C2_PP, C2_K, EYE, C2_P, "after_abort");
  endtask
  initial begin
    bus.start = 1'b0;
    set_ops(64'd0, 64'd0, 64'd0);
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
